// File: rtl/data_mem_mp.sv
// data_mem_mp: WIDTH x DEPTH data memory with one write port and two read ports.
// After reset, and again on InitReq, a clear engine sweeps every word to
// INIT_VALUE. Busy is high and writes are ignored while the sweep runs.
// Reads are combinational (REG_READ=0) or registered with write-first bypass
// (REG_READ=1).
module data_mem_mp #(
    parameter int              WIDTH      = 8,
    parameter int              DEPTH      = 256,
    parameter int              ADDR_W     = $clog2(DEPTH),
    parameter int              REG_READ   = 0,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              InitReq,
    input  logic              WriteEn,
    input  logic [ADDR_W-1:0] WriteAddr,
    input  logic [WIDTH-1:0]  WriteData,
    input  logic [ADDR_W-1:0] ReadAddrA,
    input  logic [ADDR_W-1:0] ReadAddrB,
    output logic [WIDTH-1:0]  ReadDataA,
    output logic [WIDTH-1:0]  ReadDataB,
    output logic              Busy,
    output logic              InitDone
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    // DEPTH extended by one bit so the range check also works when DEPTH is a
    // power of two and does not fit in ADDR_W bits.
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] count;
    logic [ADDR_W-1:0] count_next;
    logic              init_done;
    logic              sweep_last;
    logic              write_ok;
    logic              a_in_range;
    logic              b_in_range;
    logic [WIDTH-1:0]  raw_a;
    logic [WIDTH-1:0]  raw_b;

    logic [WIDTH-1:0]  core [DEPTH];

    assign sweep_last = (state == CLEAR) && (count == LAST_ADDR);
    assign a_in_range = {1'b0, ReadAddrA} < DEPTH_EXT;
    assign b_in_range = {1'b0, ReadAddrB} < DEPTH_EXT;
    // Out-of-range writes (only possible with non-power-of-two DEPTH) are dropped.
    assign write_ok   = (state == READY) && WriteEn && ({1'b0, WriteAddr} < DEPTH_EXT);

    // Next-state and clear-counter logic.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_next = state;
        count_next = count;
        case (state)
            CLEAR: begin
                count_next = count + 1'b1;
                if (sweep_last) begin
                    state_next = READY;
                    count_next = '0;
                end
            end
            READY: begin
                if (InitReq) begin
                    state_next = CLEAR;
                    count_next = '0;
                end
            end
            default: begin
                state_next = CLEAR;
                count_next = '0;
            end
        endcase
    end

    // State register, sweep counter and the one-cycle completion pulse.
    always_ff @(posedge Clk or negedge Reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!Reset) begin
            state     <= CLEAR;
            count     <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            init_done <= sweep_last;
        end
    end

    // Storage array: the sweep owns the write port while clearing.
    always_ff @(posedge Clk) begin
        // NOTE: the array has no reset; its contents are defined by the sweep,
        // which keeps it mappable onto plain RAM.
        if (state == CLEAR) begin
            core[count] <= INIT_VALUE;
        end else if (write_ok) begin
            core[WriteAddr] <= WriteData;
        end
    end

    assign raw_a    = a_in_range ? core[ReadAddrA] : INIT_VALUE;
    assign raw_b    = b_in_range ? core[ReadAddrB] : INIT_VALUE;
    assign Busy     = (state == CLEAR);
    assign InitDone = init_done;

    generate
        if (REG_READ == 0) begin : g_comb_read
            // A same-cycle write is seen only after the edge: old data here.
            assign ReadDataA = Busy ? INIT_VALUE : raw_a;
            assign ReadDataB = Busy ? INIT_VALUE : raw_b;
        end else begin : g_reg_read
            logic [WIDTH-1:0] q_a;
            logic [WIDTH-1:0] q_b;

            // Registered read data with write-first bypass on address match.
            always_ff @(posedge Clk or negedge Reset) begin
                if (!Reset) begin
                    q_a <= '0;
                    q_b <= '0;
                end else if (state == CLEAR) begin
                    q_a <= INIT_VALUE;
                    q_b <= INIT_VALUE;
                end else begin
                    q_a <= (write_ok && (WriteAddr == ReadAddrA)) ? WriteData : raw_a;
                    q_b <= (write_ok && (WriteAddr == ReadAddrB)) ? WriteData : raw_b;
                end
            end

            assign ReadDataA = Busy ? INIT_VALUE : q_a;
            assign ReadDataB = Busy ? INIT_VALUE : q_b;
        end
    endgenerate

endmodule

// File: tb/tb_data_mem_mp.sv
// Testbench for data_mem_mp: three instances (combinational reads, registered
// reads, and DEPTH=200 / INIT_VALUE=0x5A) driven by directed vectors.
module tb_data_mem_mp;

    logic       Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Shared stimulus for the two DEPTH=256 instances.
    logic       reset    = 1'b0;
    logic       init_req = 1'b0;
    logic       we       = 1'b0;
    logic [7:0] wa       = '0;
    logic [7:0] wd       = '0;
    logic [7:0] ra       = '0;
    logic [7:0] rb       = '0;
    logic [7:0] rda0, rdb0, rda1, rdb1;
    logic       busy0, done0, busy1, done1;

    // Stimulus for the DEPTH=200 instance.
    logic       reset2    = 1'b0;
    logic       init_req2 = 1'b0;
    logic       we2       = 1'b0;
    logic [7:0] wa2       = '0;
    logic [7:0] wd2       = '0;
    logic [7:0] ra2       = '0;
    logic [7:0] rb2       = '0;
    logic [7:0] rda2, rdb2;
    logic       busy2, done2;

    int n_applied = 0;
    int n_fail    = 0;

    data_mem_mp #(.WIDTH(8), .DEPTH(256), .REG_READ(0), .INIT_VALUE(8'h00)) dut_comb (
        .Clk(Clk), .Reset(reset), .InitReq(init_req), .WriteEn(we),
        .WriteAddr(wa), .WriteData(wd), .ReadAddrA(ra), .ReadAddrB(rb),
        .ReadDataA(rda0), .ReadDataB(rdb0), .Busy(busy0), .InitDone(done0)
    );

    data_mem_mp #(.WIDTH(8), .DEPTH(256), .REG_READ(1), .INIT_VALUE(8'h00)) dut_reg (
        .Clk(Clk), .Reset(reset), .InitReq(init_req), .WriteEn(we),
        .WriteAddr(wa), .WriteData(wd), .ReadAddrA(ra), .ReadAddrB(rb),
        .ReadDataA(rda1), .ReadDataB(rdb1), .Busy(busy1), .InitDone(done1)
    );

    data_mem_mp #(.WIDTH(8), .DEPTH(200), .REG_READ(0), .INIT_VALUE(8'h5A)) dut_odd (
        .Clk(Clk), .Reset(reset2), .InitReq(init_req2), .WriteEn(we2),
        .WriteAddr(wa2), .WriteData(wd2), .ReadAddrA(ra2), .ReadAddrB(rb2),
        .ReadDataA(rda2), .ReadDataB(rdb2), .Busy(busy2), .InitDone(done2)
    );

    typedef struct {
        logic       we;
        logic [7:0] wa;
        logic [7:0] wd;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] comb_a;   // combinational port, sampled before the edge
        logic [7:0] comb_b;
        logic [7:0] reg_a;    // registered port, sampled after the edge
        logic [7:0] reg_b;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Counts rising edges with Busy high until the sweep ends, then checks
    // the InitDone pulse. Entered with n0 sweep edges already elapsed.
    task automatic wait_sweep(input string name, input int n0, input int exp_cycles, input bit odd);
        int n = n0;
        while ((odd ? busy2 : busy0) && n < 1000) begin
            @(posedge Clk);
            n++;
            #1;
        end
        check({name, " busy cycles"}, n, exp_cycles);
        check({name, " init_done high"}, odd ? done2 : done0, 1);
        if (!odd) check({name, " reg init_done high"}, done1, 1);
        @(posedge Clk);
        #1;
        check({name, " init_done low"}, odd ? done2 : done0, 0);
    endtask

    // Reads both DEPTH=256 instances; expected value is the same for each.
    task automatic read256(input string name, input logic [7:0] addr_a, input logic [7:0] addr_b,
                           input logic [7:0] exp_a, input logic [7:0] exp_b);
        @(negedge Clk);
        ra = addr_a;
        rb = addr_b;
        #1;
        check({name, " comb A"}, rda0, exp_a);
        check({name, " comb B"}, rdb0, exp_b);
        @(posedge Clk);
        #1;
        check({name, " reg A"}, rda1, exp_a);
        check({name, " reg B"}, rdb1, exp_b);
    endtask

    task automatic read_odd(input string name, input logic [7:0] addr, input logic [7:0] exp);
        @(negedge Clk);
        ra2 = addr;
        rb2 = addr;
        #1;
        check({name, " A"}, rda2, exp);
        check({name, " B"}, rdb2, exp);
    endtask

    task automatic write_odd(input logic [7:0] addr, input logic [7:0] data);
        @(negedge Clk);
        we2 = 1'b1;
        wa2 = addr;
        wd2 = data;
        @(negedge Clk);
        we2 = 1'b0;
    endtask

    initial begin
        //           we    wa     wd     ra     rb     comb_a comb_b reg_a  reg_b
        vecs[0] = '{1'b1, 8'h10, 8'hA5, 8'h10, 8'h11, 8'h00, 8'h00, 8'hA5, 8'h00};
        vecs[1] = '{1'b0, 8'h00, 8'h00, 8'h10, 8'h10, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
        vecs[2] = '{1'b1, 8'h20, 8'h3C, 8'h20, 8'h20, 8'h00, 8'h00, 8'h3C, 8'h3C};
        vecs[3] = '{1'b0, 8'h00, 8'h00, 8'h20, 8'h21, 8'h3C, 8'h00, 8'h3C, 8'h00};
        vecs[4] = '{1'b1, 8'hFF, 8'h81, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h81, 8'h00};
        vecs[5] = '{1'b1, 8'h00, 8'h12, 8'h10, 8'hFF, 8'hA5, 8'h81, 8'hA5, 8'h81};
        vecs[6] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h20, 8'h12, 8'h3C, 8'h12, 8'h3C};
        vecs[7] = '{1'b1, 8'h10, 8'h5B, 8'h11, 8'h10, 8'h00, 8'hA5, 8'h00, 8'h5B};
        vecs[8] = '{1'b0, 8'h00, 8'h00, 8'h10, 8'h00, 8'h5B, 8'h12, 8'h5B, 8'h12};

        // Reset state of all three instances.
        ra  = 8'h10;
        rb  = 8'h00;
        ra2 = 8'h10;
        rb2 = 8'h00;
        repeat (3) @(posedge Clk);
        #1;
        check("reset busy comb", busy0, 1);
        check("reset done comb", done0, 0);
        check("reset data comb", rda0, 8'h00);
        check("reset busy reg", busy1, 1);
        check("reset data reg", rdb1, 8'h00);
        check("reset busy odd", busy2, 1);
        check("reset done odd", done2, 0);
        check("reset data odd", rda2, 8'h5A);

        @(negedge Clk);
        reset  = 1'b1;
        reset2 = 1'b1;
        wait_sweep("power-up sweep", 0, 256, 1'b0);
        read256("cleared 0/127", 8'h00, 8'h7F, 8'h00, 8'h00);
        read256("cleared 255", 8'hFF, 8'hFF, 8'h00, 8'h00);

        // Table-driven single-cycle traffic in READY.
        for (int i = 0; i < 9; i++) begin
            @(negedge Clk);
            we = vecs[i].we;
            wa = vecs[i].wa;
            wd = vecs[i].wd;
            ra = vecs[i].ra;
            rb = vecs[i].rb;
            #1;
            check($sformatf("vec%0d comb A", i), rda0, vecs[i].comb_a);
            check($sformatf("vec%0d comb B", i), rdb0, vecs[i].comb_b);
            @(posedge Clk);
            #1;
            check($sformatf("vec%0d reg A", i), rda1, vecs[i].reg_a);
            check($sformatf("vec%0d reg B", i), rdb1, vecs[i].reg_b);
        end
        @(negedge Clk);
        we = 1'b0;
        read256("post-edge comb view", 8'h10, 8'hFF, 8'h5B, 8'h81);

        // Reset with non-zero contents; writes and InitReq during the sweep
        // must be ignored and must not restart it.
        @(negedge Clk);
        ra    = 8'h10;
        rb    = 8'h00;
        reset = 1'b0;
        #1;
        check("mid reset busy", busy0, 1);
        check("mid reset done", done0, 0);
        check("mid reset forced comb", rda0, 8'h00);
        check("mid reset reg cleared", rdb1, 8'h00);
        @(negedge Clk);
        reset = 1'b1;
        repeat (20) @(posedge Clk);
        @(negedge Clk);
        #1;
        check("sweep forced read", rdb0, 8'h00);
        we       = 1'b1;
        wa       = 8'h05;
        wd       = 8'hFF;
        init_req = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        we       = 1'b0;
        init_req = 1'b0;
        wait_sweep("reset sweep", 23, 256, 1'b0);
        read256("clear-time write dropped", 8'h05, 8'h10, 8'h00, 8'h00);
        read256("old data cleared", 8'h00, 8'hFF, 8'h00, 8'h00);

        // InitReq in READY, with a write in the same cycle.
        @(negedge Clk);
        we = 1'b1;
        wa = 8'h40;
        wd = 8'h77;
        @(negedge Clk);
        we = 1'b0;
        read256("before re-clear", 8'h40, 8'h40, 8'h77, 8'h77);
        @(negedge Clk);
        init_req = 1'b1;
        we       = 1'b1;
        wa       = 8'h41;
        wd       = 8'h99;
        @(posedge Clk);
        #1;
        init_req = 1'b0;
        we       = 1'b0;
        check("initreq busy next cycle", busy0, 1);
        check("initreq reg busy", busy1, 1);
        check("initreq done low", done0, 0);
        wait_sweep("initreq sweep", 0, 256, 1'b0);
        read256("re-cleared", 8'h40, 8'h41, 8'h00, 8'h00);

        // DEPTH=200, INIT_VALUE=0x5A.
        @(negedge Clk);
        reset2 = 1'b0;
        @(negedge Clk);
        reset2 = 1'b1;
        wait_sweep("odd sweep", 0, 200, 1'b1);
        read_odd("odd init 0", 8'd0, 8'h5A);
        read_odd("odd init 199", 8'd199, 8'h5A);
        read_odd("odd oob read", 8'd210, 8'h5A);
        write_odd(8'd10, 8'h11);
        write_odd(8'd199, 8'h22);
        write_odd(8'd210, 8'h33);
        read_odd("odd write 10", 8'd10, 8'h11);
        read_odd("odd write 199", 8'd199, 8'h22);
        read_odd("odd oob write dropped", 8'd210, 8'h5A);

        // Reset at counter=100 restarts the sweep from zero.
        @(negedge Clk);
        reset2 = 1'b0;
        @(negedge Clk);
        reset2 = 1'b1;
        repeat (100) @(posedge Clk);
        #1;
        reset2 = 1'b0;
        #1;
        check("odd mid-sweep reset busy", busy2, 1);
        check("odd mid-sweep reset done", done2, 0);
        @(negedge Clk);
        reset2 = 1'b1;
        wait_sweep("odd restart sweep", 0, 200, 1'b1);
        read_odd("odd restart 10", 8'd10, 8'h5A);
        read_odd("odd restart 199", 8'd199, 8'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
        $finish;
    end

endmodule
